complex_dot_product_row_feeder: RTL and testbench
=================================================

# complex_dot_product_row_feeder

Job-level initiator for the conjugate complex 8-wide dot-product unit. On `start` it clears the unit, fetches paired row packages of `no_of_units` complex elements from two dual-read buffers, and presents them on the unit's row inputs with the required `read_now` pulse cadence. It then waits for the unit's `finish`, and hands the result upstream over a valid/ready handshake. It sits between the solver control FSM and one dot-product instance.

## Interface
- element_width, 64, bits per complex element (real/imag halves)
- no_of_units, 8, elements per package (even)
- AW, 10, package address width of the row buffers
- TIMEOUT, 256, max cycles from last package pulse to `dp_finish`

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  job request; sampled only in IDLE
- len  in  32  vector length in elements; sampled with `start`
- base_addr  in  AW  package address of element 0
- busy  out  1  high from accepted `start` until return to IDLE
- rd_en  out  1  buffer read strobe
- rd_addr  out  AW  package address; data returns next cycle
- rd_data_a  in  element_width*no_of_units  first-row package
- rd_data_b  in  element_width*no_of_units  second-row package
- dp_reset  out  1  reset to dot-product unit
- dp_read_now  out  1  package-present pulse
- dp_total  out  32  length forwarded to unit
- dp_row_a  out  element_width*no_of_units  first-row package
- dp_row_b  out  element_width*no_of_units  second-row package
- dp_finish  in  1  unit done (sticky until `dp_reset`)
- dp_result  in  element_width  unit result
- result  out  element_width  captured dot product
- result_valid  out  1  result available
- result_ready  in  1  upstream accepts result
- error  out  1  sticky job error; cleared by next accepted `start`

## Operation
- P = len/no_of_units packages. Reject if len==0, len mod no_of_units != 0, or P > 2^AW. Rejection: `error`=1, no fetch, stay IDLE, `busy` stays 0.
- States: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE. Any state -> IDLE on timeout, with `error`=1.
- IDLE: accept `start` if valid. Latch `len` into `dp_total` (held for the whole job), clear `error`, go to CLEAR.
- CLEAR: `dp_reset`=1 for exactly 2 cycles, then STREAM.
- STREAM: package counter k=0..P-1. Even phase: `rd_en`=1, `rd_addr`=base_addr+k (mod 2^AW). Odd phase: `dp_read_now`=1. `dp_row_a/b` load `rd_data_a/b` on the edge ending the odd phase. After package P-1's odd phase, go to DRAIN.
- DRAIN: rows hold the last package. Timeout counter runs from 0. `dp_finish`=1 captures `dp_result` into `result`, sets `result_valid`, and goes to DONE. Counter reaching TIMEOUT gives error/IDLE.
- DONE: hold `result` and `result_valid` until `result_ready`=1. Then clear `result_valid` and go to IDLE; `busy` drops the same edge.
- `start` outside IDLE is ignored. `start` arriving on the same cycle as the DONE handshake is not accepted until the next cycle.

## Timing
- Reset values: busy 0, rd_en 0, rd_addr 0, dp_read_now 0, dp_total 0, dp_row_a/b 0, result 0, result_valid 0, error 0. `dp_reset`=1 whenever `reset`=1.
- Start accepted at cycle 0: `dp_reset` high in cycles 1-2. First `rd_en` in cycle 3. Pulse k falls in cycle 4+2k.
- Pulse at cycle N: `dp_row_a/b` stable in cycles N+1 and N+2 (the unit captures the upper half, then the lower half). Next pulse at N+2.
- `dp_read_now` is never high on consecutive cycles. The package period is exactly 2 cycles with no bubbles.
- Reset mid-job: returns to IDLE next edge. All outputs take their reset values; any pending result is discarded.
- `dp_finish` already high on DRAIN entry: capture on the first DRAIN cycle.

## Test plan
- len=16, base=5, buffers hold a ramp: `rd_addr` 5,6 in cycles 3,5; pulses in cycles 4,6; `dp_total`=16. Model `dp_finish` 20 cycles later with `dp_result`=64'hABCD -> `result`=64'hABCD, `result_valid`=1, held until `result_ready`.
- len=12 (not a multiple of 8), then len=0: `error`=1, `busy`=0, no `rd_en`, no `dp_reset`.
- len=8, base=2^AW-1 -> single package at address 1023. Then a second job with len=24, base=1023 -> addresses 1023,0,1 (wrap).
- `dp_finish` never asserted, TIMEOUT=256 -> `error`=1 at 256 cycles after the last pulse, state IDLE, `result_valid`=0.
- `reset` asserted during STREAM package 3 of 8 -> all outputs at reset values next cycle. A new `start` with len=64 runs 8 pulses cleanly.
- `result_ready` held low 10 cycles, `start` pulsed in DONE -> ignored. Then `result_ready`=1 -> IDLE. A `start` on the next cycle is accepted.

Source files
------------

// File: rtl/complex_dot_product_row_feeder.sv
// rtl/complex_dot_product_row_feeder.sv - job initiator feeding paired row packages to the conjugate complex dot-product unit
module complex_dot_product_row_feeder #(
    parameter int ELEMENT_WIDTH = 64,
    parameter int NO_OF_UNITS   = 8,
    parameter int AW            = 10,
    parameter int TIMEOUT       = 256
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [31:0]                          len,
    input  logic [AW-1:0]                        base_addr,
    output logic                                 busy,
    output logic                                 rd_en,
    output logic [AW-1:0]                        rd_addr,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_data_a,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_data_b,
    output logic                                 dp_reset,
    output logic                                 dp_read_now,
    output logic [31:0]                          dp_total,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] dp_row_a,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] dp_row_b,
    input  logic                                 dp_finish,
    input  logic [ELEMENT_WIDTH-1:0]             dp_result,
    output logic [ELEMENT_WIDTH-1:0]             result,
    output logic                                 result_valid,
    input  logic                                 result_ready,
    output logic                                 error
);
    localparam int PW = ELEMENT_WIDTH * NO_OF_UNITS;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            base_q, base_d;
    logic [AW-1:0]            k_q, k_d;
    logic [AW-1:0]            last_q, last_d;
    logic                     phase_q, phase_d;
    logic [TW-1:0]            cnt_q, cnt_d;
    logic [31:0]              total_q, total_d;
    logic [PW-1:0]            row_a_q, row_a_d;
    logic [PW-1:0]            row_b_q, row_b_d;
    logic [ELEMENT_WIDTH-1:0] result_q, result_d;
    logic                     rv_q, rv_d;
    logic                     err_q, err_d;

    logic [31:0] pkgs;
    logic        len_ok;

    assign pkgs   = len / 32'(NO_OF_UNITS);
    assign len_ok = (len != 32'd0) && ((len % 32'(NO_OF_UNITS)) == 32'd0)
                    && (pkgs <= 32'(2 ** AW));

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        k_d      = k_q;
        last_d   = last_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        total_d  = total_q;
        row_a_d  = row_a_q;
        row_b_d  = row_b_q;
        result_d = result_q;
        rv_d     = rv_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        err_d   = 1'b0;
                        total_d = len;
                        base_d  = base_addr;
                        last_d  = AW'(pkgs - 32'd1);
                        phase_d = 1'b0;
                        state_d = S_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // phase_q doubles as the two-cycle clear counter
            S_CLEAR: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    k_d     = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    row_a_d = rd_data_a;
                    row_b_d = rd_data_b;
                    if (k_q == last_q) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        k_d = k_q + AW'(1);
                    end
                end
            end
            // counter starts one cycle after the last pulse, so the error lands TIMEOUT cycles after it
            S_DRAIN: begin
                if (dp_finish) begin
                    result_d = dp_result;
                    rv_d     = 1'b1;
                    state_d  = S_DONE;
                end else if (cnt_q == TW'(TIMEOUT - 2)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    rv_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            k_q      <= '0;
            last_q   <= '0;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            total_q  <= '0;
            row_a_q  <= '0;
            row_b_q  <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            k_q      <= k_d;
            last_q   <= last_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            total_q  <= total_d;
            row_a_q  <= row_a_d;
            row_b_q  <= row_b_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign rd_en        = (state_q == S_STREAM) && !phase_q;
    assign rd_addr      = rd_en ? (base_q + k_q) : '0;
    assign dp_read_now  = (state_q == S_STREAM) && phase_q;
    assign dp_reset     = reset || (state_q == S_CLEAR);
    assign dp_total     = total_q;
    assign dp_row_a     = row_a_q;
    assign dp_row_b     = row_b_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign error        = err_q;

endmodule

// File: tb/tb_complex_dot_product_row_feeder.sv
// tb/tb_complex_dot_product_row_feeder.sv - directed bench with a job-timeline model of the row feeder
module tb_complex_dot_product_row_feeder;
    localparam int EW = 64;
    localparam int NU = 8;
    localparam int AW = 10;
    localparam int TO = 256;
    localparam int PW = EW * NU;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   len;
    logic [AW-1:0] base_addr;
    logic          busy, rd_en, dp_reset, dp_read_now, result_valid, error;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_data_a = '0;
    logic [PW-1:0] rd_data_b = '0;
    logic [31:0]   dp_total;
    logic [PW-1:0] dp_row_a, dp_row_b;
    logic          dp_finish;
    logic [EW-1:0] dp_result, result;
    logic          result_ready;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    complex_dot_product_row_feeder #(
        .ELEMENT_WIDTH(EW), .NO_OF_UNITS(NU), .AW(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .base_addr(base_addr),
        .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .dp_reset(dp_reset), .dp_read_now(dp_read_now), .dp_total(dp_total),
        .dp_row_a(dp_row_a), .dp_row_b(dp_row_b),
        .dp_finish(dp_finish), .dp_result(dp_result),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .error(error)
    );

    always #5 clk = ~clk;

    // buffer contents: a ramp of element indices tagged per row
    function automatic logic [PW-1:0] pat(input logic [AW-1:0] a, input logic sel);
        logic [PW-1:0] v;
        for (int j = 0; j < NU; j++)
            v[j*EW +: EW] = {(sel ? 32'hBBBB_0000 : 32'hAAAA_0000), 32'(a) * 32'd8 + 32'(j)};
        return v;
    endfunction

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= pat(rd_addr, 1'b0);
            rd_data_b <= pat(rd_addr, 1'b1);
        end
    end

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // model: mode 0 idle, 1 job running with t = cycles since acceptance, 2 result waiting
    int            m_mode = 0;
    int            t = 0;
    int            np = 0;
    logic [AW-1:0] m_base = '0;
    logic [31:0]   m_total = '0;
    logic [PW-1:0] m_ra = '0, m_rb = '0;
    logic [EW-1:0] m_res = '0;
    logic          m_rv = 1'b0, m_err = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; t = 0; np = 0; m_base = '0; m_total = '0;
            m_ra = '0; m_rb = '0; m_res = '0; m_rv = 1'b0; m_err = 1'b0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    if (len != 0 && len % 8 == 0 && len / 8 <= 1024) begin
                        m_err = 1'b0; m_total = len; np = int'(len / 8);
                        m_base = base_addr; t = 1; m_mode = 1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                1: begin
                    if (t >= 3 + 2*np && dp_finish) begin
                        m_res = dp_result; m_rv = 1'b1; m_mode = 2;
                    end else if (t == 2 + 2*np + TO - 1) begin
                        m_err = 1'b1; m_mode = 0;
                    end else begin
                        if (t >= 4 && t <= 2 + 2*np && t % 2 == 0) begin
                            m_ra = pat(AW'(m_base + (t - 4) / 2), 1'b0);
                            m_rb = pat(AW'(m_base + (t - 4) / 2), 1'b1);
                        end
                        t++;
                    end
                end
                default: if (result_ready) begin
                    m_rv = 1'b0; m_mode = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic          run, e_rd;
            logic [AW-1:0] e_addr;
            run    = (m_mode == 1);
            e_rd   = run && t >= 3 && t <= 1 + 2*np && t % 2 == 1;
            e_addr = e_rd ? AW'(m_base + (t - 3) / 2) : '0;
            check("m_busy", busy, m_mode != 0);
            check("m_rd_en", rd_en, e_rd);
            check("m_rd_addr", rd_addr, e_addr);
            check("m_read_now", dp_read_now, run && t >= 4 && t <= 2 + 2*np && t % 2 == 0);
            check("m_dp_reset", dp_reset, reset || (run && t <= 2));
            check("m_dp_total", dp_total, m_total);
            check("m_row_a", dp_row_a, m_ra);
            check("m_row_b", dp_row_b, m_rb);
            check("m_result", result, m_res);
            check("m_result_valid", result_valid, m_rv);
            check("m_error", error, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] l, input logic [AW-1:0] b);
        len = l; base_addr = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_job(input int wait_cyc, input logic [EW-1:0] v);
        repeat (wait_cyc) tick();
        dp_result = v; dp_finish = 1'b1;
        tick();
        check("fin_valid", result_valid, 1'b1);
        check("fin_result", result, v);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0; dp_finish = 1'b0;
        check("fin_idle", busy, 1'b0);
        check("fin_valid_clr", result_valid, 1'b0);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; start = 1'b0; len = '0; base_addr = '0;
        dp_finish = 1'b0; dp_result = '0; result_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_dp_reset", dp_reset, 1'b1);
        check("rst_total", dp_total, 32'd0);
        check("rst_error", error, 1'b0);
        reset = 1'b0;
        tick();

        // len=16 base=5
        start_job(16, 5);
        check("a_clear_c1", dp_reset, 1'b1);
        tick(); tick();
        check("a_rd_en_c3", rd_en, 1'b1);
        check("a_addr_c3", rd_addr, 10'd5);
        tick();
        check("a_pulse_c4", dp_read_now, 1'b1);
        tick();
        check("a_addr_c5", rd_addr, 10'd6);
        check("a_row_c5", dp_row_a[63:0], 64'hAAAA_0000_0000_0028);
        tick();
        check("a_pulse_c6", dp_read_now, 1'b1);
        check("a_total", dp_total, 32'd16);
        repeat (20) tick();
        dp_result = 64'hABCD; dp_finish = 1'b1;
        tick();
        check("a_result", result, 64'hABCD);
        check("a_valid", result_valid, 1'b1);
        repeat (3) tick();
        check("a_held", result, 64'hABCD);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0; dp_finish = 1'b0;
        check("a_idle", busy, 1'b0);

        // rejected lengths
        start_job(12, 0);
        check("rej12_err", error, 1'b1);
        check("rej12_busy", busy, 1'b0);
        tick();
        start_job(0, 0);
        check("rej0_err", error, 1'b1);
        start_job(32'd8200, 0);
        check("rejbig_busy", busy, 1'b0);
        tick();

        // single package at the top address, then a wrapping job
        start_job(8, 10'd1023);
        check("b_err_clr", error, 1'b0);
        tick(); tick();
        check("b_addr", rd_addr, 10'd1023);
        tick();
        finish_job(1, 64'h1111);
        start_job(24, 10'd1023);
        tick(); tick();
        check("w_addr0", rd_addr, 10'd1023);
        tick(); tick();
        check("w_addr1", rd_addr, 10'd0);
        tick(); tick();
        check("w_addr2", rd_addr, 10'd1);
        finish_job(2, 64'h2222);

        // timeout: last pulse at cycle 4
        start_job(8, 0);
        repeat (258) tick();
        check("to_err_c259", error, 1'b0);
        check("to_busy_c259", busy, 1'b1);
        tick();
        check("to_err_c260", error, 1'b1);
        check("to_busy_c260", busy, 1'b0);
        check("to_valid", result_valid, 1'b0);

        // finish already high when DRAIN is entered
        start_job(8, 0);
        dp_result = 64'h7777; dp_finish = 1'b1;
        repeat (5) tick();
        check("pre_valid_c6", result_valid, 1'b1);
        check("pre_result", result, 64'h7777);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0; dp_finish = 1'b0;

        // reset mid-stream, then a clean 8-package job
        start_job(64, 0);
        repeat (8) tick();
        reset = 1'b1;
        tick();
        check("mr_busy", busy, 1'b0);
        check("mr_rd_en", rd_en, 1'b0);
        check("mr_row", dp_row_a, '0);
        check("mr_total", dp_total, 32'd0);
        reset = 1'b0;
        tick();
        start_job(64, 10'd200);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (dp_read_now) pulses++;
            tick();
        end
        check("mr_pulses", pulses, 8);
        finish_job(0, 64'h5555);

        // DONE holds; start ignored there and on the handshake cycle
        start_job(8, 3);
        repeat (4) tick();
        dp_result = 64'h9999; dp_finish = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            start = (i == 4); len = 16;
            tick();
        end
        start = 1'b0;
        check("d_busy", busy, 1'b1);
        check("d_total", dp_total, 32'd8);
        check("d_result", result, 64'h9999);
        result_ready = 1'b1; start = 1'b1; len = 16; base_addr = 7;
        tick();
        result_ready = 1'b0;
        check("d_hs_idle", busy, 1'b0);
        tick();
        start = 1'b0; dp_finish = 1'b0;
        check("d_next_busy", busy, 1'b1);
        check("d_next_total", dp_total, 32'd16);
        finish_job(6, 64'h4242);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
